// File: rtl/call_register_if.sv
// Button-panel / FSM side bundle for call_register.
//   slave  : the call_register itself (reads raw buttons and FSM state,
//            drives the latched request vectors).
//   master : whoever drives buttons and FSM state (FSM + pin model).
// Signals:
//   power                  power switch, low drops all requests
//   raw_up/raw_down/raw_car asynchronous, bouncing button inputs
//   status/floor           FSM state and current floor
//   nextup/nextdown        FSM travel direction
//   upcall/downcall/floor_btn latched requests, any_call = OR of them
interface call_register_if #(
  parameter int FLOORS = 8
);
  logic              power;
  logic [FLOORS-1:0] raw_up;
  logic [FLOORS-1:0] raw_down;
  logic [FLOORS-1:0] raw_car;
  logic [3:0]        status;
  logic [2:0]        floor;
  logic              nextup;
  logic              nextdown;
  logic [FLOORS-1:0] upcall;
  logic [FLOORS-1:0] downcall;
  logic [FLOORS-1:0] floor_btn;
  logic              any_call;

  modport slave (
    input  power, raw_up, raw_down, raw_car, status, floor, nextup, nextdown,
    output upcall, downcall, floor_btn, any_call
  );

  modport master (
    output power, raw_up, raw_down, raw_car, status, floor, nextup, nextdown,
    input  upcall, downcall, floor_btn, any_call
  );
endinterface

// File: rtl/call_register.sv
// call_register: turns raw hall/car buttons into the latched request vectors
// consumed by the elevator FSM.  Every button goes through its own
// synchroniser + debouncer channel which emits a one-cycle press pulse; the
// pulses set request bits that are cleared when the FSM opens the door at the
// matching floor in a compatible direction.
// Ports:
//   clk   system clock (shared with the FSM)
//   rst   synchronous active-high reset
//   bus   call_register_if.slave (buttons, FSM state, request outputs)

// One button channel: 2-flop synchroniser, saturating debounce counter and
// rising-edge detect on the debounced level.
module call_register_chan #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic       s1_q, s2_q, deb_q;
  logic [3:0] cnt_q, cnt_d;
  logic       deb;

  assign deb     = (cnt_q == DB);
  assign press_o = deb & ~deb_q;

  // Counter restarts whenever the synced level drops, so a re-press needs
  // at least one synced-low cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!s2_q)    cnt_d = '0;
    else if (!deb) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      deb_q <= deb;
    end
  end
endmodule

module call_register #(
  parameter int FLOORS      = 8,
  parameter int DEBOUNCE    = 4,
  parameter int ST_SHUTDOWN = 0,
  parameter int ST_OPENED   = 7
) (
  input logic             clk,
  input logic             rst,
  call_register_if.slave  bus
);
  localparam int NCH = 3 * FLOORS;
  // No "up" at the top floor and no "down" at the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [NCH-1:0]    raw_all, press_all;
  logic [FLOORS-1:0] up_q, dn_q, car_q, up_d, dn_d, car_d;
  logic [FLOORS-1:0] sel, clr_up, clr_dn;
  logic              any_q, any_d;
  logic              off, bidir;

  assign raw_all = {bus.raw_car, bus.raw_down, bus.raw_up};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    call_register_chan #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_all[g]),
      .press_o (press_all[g])
    );
  end

  // One-hot floor select while the door is open; an out-of-range floor
  // simply matches nothing.
  for (genvar f = 0; f < FLOORS; f++) begin : g_sel
    assign sel[f] = (bus.status == 4'(ST_OPENED)) && (int'(bus.floor) == f);
  end

  assign off    = !bus.power || (bus.status == 4'(ST_SHUTDOWN));
  assign bidir  = !bus.nextup && !bus.nextdown;
  assign clr_up = sel & {FLOORS{bus.nextup   | bidir}};
  assign clr_dn = sel & {FLOORS{bus.nextdown | bidir}};

  // Clear is applied after the set, so a same-edge press + clear leaves 0.
  always_comb begin
    up_d  = (up_q  | press_all[FLOORS-1:0])          & ~clr_up & UP_MASK;
    dn_d  = (dn_q  | press_all[2*FLOORS-1:FLOORS])   & ~clr_dn & DN_MASK;
    car_d = (car_q | press_all[3*FLOORS-1:2*FLOORS]) & ~sel;
    if (off) begin
      up_d  = '0;
      dn_d  = '0;
      car_d = '0;
    end
    any_d = |{up_d, dn_d, car_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q  <= '0;
      dn_q  <= '0;
      car_q <= '0;
      any_q <= 1'b0;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      car_q <= car_d;
      any_q <= any_d;
    end
  end

  assign bus.upcall    = up_q;
  assign bus.downcall  = dn_q;
  assign bus.floor_btn = car_q;
  assign bus.any_call  = any_q;
endmodule

// File: tb/tb_call_register.sv
module tb_call_register;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [24:0] sb[$];   // expected {upcall, downcall, floor_btn, any_call}

  call_register_if #(.FLOORS(8)) bus ();

  call_register u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.power = 1'b1; bus.status = 4'd1; bus.floor = 3'd0;
    bus.nextup = 1'b0; bus.nextdown = 1'b0;
    bus.raw_up = '0; bus.raw_down = '0; bus.raw_car = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  // Pop one expectation per edge and compare against the outputs.
  task automatic run_edges(input string nm, input int n);
    logic [24:0] got, e;
    for (int i = 1; i <= n; i++) begin
      step(1);
      got = {bus.upcall, bus.downcall, bus.floor_btn, bus.any_call};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s edge%0d got=%h exp=%h", nm, i, got, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [24:0] got;
    idle_inputs();
    bus.raw_up = '1; bus.raw_down = '1; bus.raw_car = '1;
    rst = 1'b1; step(2);
    got = {bus.upcall, bus.downcall, bus.floor_btn, bus.any_call};
    checks++;
    if (got !== 25'h0) begin
      errors++; $display("FAIL reset got=%h exp=%h", got, 25'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) sb.push_back(25'h0);
    sb.push_back({8'h7F, 8'hFE, 8'hFF, 1'b1});
    run_edges("latency", 7);
  endtask

  task automatic test_rst_mid();
    idle_inputs(); do_reset();
    bus.raw_car = 8'h01; step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    for (int i = 1; i <= 6; i++) sb.push_back(25'h0);
    sb.push_back({8'h00, 8'h00, 8'h01, 1'b1});
    run_edges("rst_mid", 7);
  endtask

  task automatic test_debounce();
    idle_inputs(); do_reset();
    bus.raw_car = 8'h08; step(3); bus.raw_car = 8'h00;
    for (int i = 0; i < 10; i++) sb.push_back(25'h0);
    run_edges("short_pulse", 10);
    bus.raw_car = 8'h08;
    for (int i = 1; i <= 6; i++) sb.push_back(25'h0);
    for (int i = 0; i < 4; i++) sb.push_back({8'h00, 8'h00, 8'h08, 1'b1});
    run_edges("held", 10);
    bus.raw_car = 8'h00;
  endtask

  task automatic set_floor2();
    idle_inputs(); do_reset();
    bus.raw_up = 8'h04; bus.raw_down = 8'h04; bus.raw_car = 8'h04;
    step(7);
    bus.raw_up = 8'h00; bus.raw_down = 8'h00; bus.raw_car = 8'h00;
  endtask

  task automatic test_clear();
    set_floor2();
    // Wrong floor: nothing cleared.
    bus.floor = 3'd5; bus.status = 4'd7;
    sb.push_back({8'h04, 8'h04, 8'h04, 1'b1});
    run_edges("clr_other_floor", 1);
    bus.floor = 3'd2; bus.nextup = 1'b1;
    sb.push_back({8'h00, 8'h04, 8'h00, 1'b1});
    run_edges("clr_up", 1);
    set_floor2();
    bus.floor = 3'd2; bus.status = 4'd7; bus.nextdown = 1'b1;
    sb.push_back({8'h04, 8'h00, 8'h00, 1'b1});
    run_edges("clr_down", 1);
    set_floor2();
    bus.floor = 3'd2; bus.status = 4'd7;
    sb.push_back(25'h0);
    run_edges("clr_idle", 1);
  endtask

  task automatic test_ends();
    idle_inputs(); do_reset();
    bus.raw_up = 8'h80; bus.raw_down = 8'h01;
    for (int i = 0; i < 20; i++) sb.push_back(25'h0);
    run_edges("tied_ends", 20);
  endtask

  task automatic test_power();
    idle_inputs(); do_reset();
    bus.raw_up = 8'hA5; bus.raw_down = 8'hA5; bus.raw_car = 8'hA5;
    step(6);
    sb.push_back({8'h25, 8'hA4, 8'hA5, 1'b1});
    run_edges("a5_set", 1);
    bus.raw_up = '0; bus.raw_down = '0; bus.raw_car = '0;
    bus.power = 1'b0;
    sb.push_back(25'h0);
    run_edges("power_off", 1);
    bus.raw_car = 8'h10;
    for (int i = 0; i < 10; i++) sb.push_back(25'h0);
    run_edges("press_while_off", 10);
    bus.power = 1'b1;
    for (int i = 0; i < 10; i++) sb.push_back(25'h0);
    run_edges("held_through_on", 10);
    bus.raw_car = 8'h00; step(3);
    bus.raw_car = 8'h10;
    for (int i = 1; i <= 6; i++) sb.push_back(25'h0);
    sb.push_back({8'h00, 8'h00, 8'h10, 1'b1});
    run_edges("repress_on", 7);
    bus.status = 4'd0;
    sb.push_back(25'h0);
    run_edges("shutdown", 1);
  endtask

  task automatic test_open_hold();
    idle_inputs(); do_reset();
    bus.floor = 3'd4; bus.status = 4'd7;
    bus.raw_car = 8'h10;
    for (int i = 0; i < 10; i++) sb.push_back(25'h0);
    run_edges("press_while_open", 10);
    bus.status = 4'd8;
    for (int i = 0; i < 5; i++) sb.push_back(25'h0);
    run_edges("held_after_close", 5);
    bus.raw_car = 8'h00; step(3);
    bus.raw_car = 8'h10;
    for (int i = 1; i <= 6; i++) sb.push_back(25'h0);
    sb.push_back({8'h00, 8'h00, 8'h10, 1'b1});
    run_edges("repress_closed", 7);
  endtask

  initial begin
    test_reset();
    test_rst_mid();
    test_debounce();
    test_clear();
    test_ends();
    test_power();
    test_open_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
